// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: state encoding,
// requester count and a one-hot helper.
package mux4_rr_arbiter_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: returns the first set request bit found scanning
// from ptr upward (mod 4), plus a flag telling whether any bit was set.
module rr_pick4
   import mux4_rr_arbiter_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] idx,
   output logic       any
);

   logic [1:0] cand;

   // Scan from the lowest priority back to ptr so the last hit is the winner.
   always_comb begin
      idx  = 2'd0;
      any  = 1'b0;
      cand = 2'd0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with a bounded hold window driving the select of a
// shared 4:1 mux, with the selected data registered onto z.
module mux4_rr_arbiter #(
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    req,
   input  logic [DW-1:0] i0,
   input  logic [DW-1:0] i1,
   input  logic [DW-1:0] i2,
   input  logic [DW-1:0] i3,
   output logic [3:0]    gnt,
   output logic          s1,
   output logic          s0,
   output logic [DW-1:0] z,
   output logic          z_valid
);

   import mux4_rr_arbiter_pkg::*;

   localparam int            HW       = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   arb_state_t    state, state_n;
   logic [1:0]    ptr, ptr_n;
   logic [1:0]    sel, sel_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic          grant_n;
   logic [3:0]    gnt_n;
   logic [DW-1:0] sel_data, z_n;
   logic          zv_n;
   logic [1:0]    pick_ptr, pick_idx;
   logic          pick_any;

   // At a handover the current holder drops to lowest priority.
   assign pick_ptr = (state == GRANT) ? sel + 2'd1 : ptr;

   rr_pick4 u_pick (
      .req (req),
      .ptr (pick_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         sel      <= 2'd0;
         hold_cnt <= '0;
         gnt      <= 4'b0000;
         z        <= '0;
         z_valid  <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         sel      <= sel_n;
         hold_cnt <= hold_n;
         gnt      <= gnt_n;
         z        <= z_n;
         z_valid  <= zv_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      sel_n   = sel;
      hold_n  = hold_cnt;
      grant_n = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_n = GRANT;
               sel_n   = pick_idx;
               hold_n  = HW'(1);
               grant_n = 1'b1;
            end
         end
         GRANT: begin
            if (req[sel] && (hold_cnt < HOLD_MAX)) begin
               hold_n  = hold_cnt + HW'(1);
               grant_n = 1'b1;
            end else begin
               ptr_n = sel + 2'd1;
               if (pick_any) begin
                  sel_n   = pick_idx;
                  hold_n  = HW'(1);
                  grant_n = 1'b1;
               end else begin
                  state_n = IDLE;
                  hold_n  = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // z follows whoever held the grant during the cycle just ending.
   always_comb begin
      gnt_n = grant_n ? onehot4(sel_n) : 4'b0000;
      case (sel)
         2'd0:    sel_data = i0;
         2'd1:    sel_data = i1;
         2'd2:    sel_data = i2;
         default: sel_data = i3;
      endcase
      z_n  = (|gnt) ? sel_data : z;
      zv_n = |gnt;
   end

   assign s1 = sel[1];
   assign s0 = sel[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter: a table of single-cycle vectors
// followed by hand-written contention, hold-window and mid-grant reset runs.
module tb_mux4_rr_arbiter;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic [7:0] z;
      logic       zv;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [7:0] i0, i1, i2, i3;
   logic [3:0] gnt;
   logic       s1, s0;
   logic [7:0] z;
   logic       z_valid;

   int n_cmp;
   int n_bad;

   logic [7:0] dat [4];
   vec_t       tbl [11];

   mux4_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .i0      (i0),
      .i1      (i1),
      .i2      (i2),
      .i3      (i3),
      .gnt     (gnt),
      .s1      (s1),
      .s0      (s0),
      .z       (z),
      .z_valid (z_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic r, input logic [3:0] rq);
      rst = r;
      req = rq;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] es,
                              input logic [7:0] ez, input logic ezv);
      n_cmp++;
      if (gnt !== eg) begin
         n_bad++;
         $display("[TB] FAIL %s gnt: got %b expected %b", name, gnt, eg);
      end
      n_cmp++;
      if ({s1, s0} !== es) begin
         n_bad++;
         $display("[TB] FAIL %s sel: got %b expected %b", name, {s1, s0}, es);
      end
      n_cmp++;
      if (z !== ez) begin
         n_bad++;
         $display("[TB] FAIL %s z: got %h expected %h", name, z, ez);
      end
      n_cmp++;
      if (z_valid !== ezv) begin
         n_bad++;
         $display("[TB] FAIL %s z_valid: got %b expected %b", name, z_valid, ezv);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      dat[0] = 8'h10;
      dat[1] = 8'hA5;
      dat[2] = 8'h3C;
      dat[3] = 8'hC3;
      i0 = dat[0];
      i1 = dat[1];
      i2 = dat[2];
      i3 = dat[3];
      rst = 1'b1;
      req = 4'b1111;

      // Reset, single requester, then early-release handover (ptr ends at 2).
      tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'b00, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 2'b00, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 4'b0010, 4'b0010, 2'b01, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 4'b0010, 4'b0010, 2'b01, 8'hA5, 1'b1};
      tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 2'b01, 8'hA5, 1'b1};
      tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'b01, 8'hA5, 1'b0};
      tbl[6]  = '{1'b0, 4'b0011, 4'b0001, 2'b00, 8'hA5, 1'b0};
      tbl[7]  = '{1'b0, 4'b0011, 4'b0001, 2'b00, 8'h10, 1'b1};
      tbl[8]  = '{1'b0, 4'b0010, 4'b0010, 2'b01, 8'h10, 1'b1};
      tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 2'b01, 8'hA5, 1'b1};
      tbl[10] = '{1'b0, 4'b0000, 4'b0000, 2'b01, 8'hA5, 1'b0};

      for (int v = 0; v < 11; v++) begin
         applyStimulus(tbl[v].rst, tbl[v].req);
         checkOutput($sformatf("vec%0d", v), tbl[v].gnt, tbl[v].sel, tbl[v].z, tbl[v].zv);
      end

      // Full contention: four cycles per requester, rotating 0,1,2,3,0.
      applyStimulus(1'b1, 4'b1111);
      checkOutput("cont_rst", 4'b0000, 2'b00, 8'h00, 1'b0);
      for (int c = 0; c < 17; c++) begin
         int k;
         int kp;
         k  = (c / 4) % 4;
         kp = ((c - 1) / 4) % 4;
         applyStimulus(1'b0, 4'b1111);
         checkOutput($sformatf("cont%0d", c), 4'(1 << k), 2'(k),
                     (c == 0) ? 8'h00 : dat[kp], c != 0);
      end

      // Lone requester is regranted across the window boundary with no gap.
      applyStimulus(1'b1, 4'b0000);
      checkOutput("lone_rst", 4'b0000, 2'b00, 8'h00, 1'b0);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b0, 4'b0100);
         checkOutput($sformatf("lone%0d", c), 4'b0100, 2'b10,
                     (c == 0) ? 8'h00 : 8'h3C, c != 0);
      end

      // Reset while requester 3 holds the grant with z_valid in flight.
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b1000);
      checkOutput("mid_g0", 4'b1000, 2'b11, 8'h00, 1'b0);
      applyStimulus(1'b0, 4'b1000);
      checkOutput("mid_g1", 4'b1000, 2'b11, 8'hC3, 1'b1);
      applyStimulus(1'b1, 4'b1001);
      checkOutput("mid_rst", 4'b0000, 2'b00, 8'h00, 1'b0);
      applyStimulus(1'b0, 4'b1001);
      checkOutput("mid_a0", 4'b0001, 2'b00, 8'h00, 1'b0);
      for (int c = 1; c < 4; c++) begin
         applyStimulus(1'b0, 4'b1001);
         checkOutput($sformatf("mid_a%0d", c), 4'b0001, 2'b00, 8'h10, 1'b1);
      end
      applyStimulus(1'b0, 4'b1001);
      checkOutput("mid_b0", 4'b1000, 2'b11, 8'h10, 1'b1);
      applyStimulus(1'b0, 4'b1001);
      checkOutput("mid_b1", 4'b1000, 2'b11, 8'hC3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
